// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: shifts a WIDTH-bit word out MSB-first on x_out.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready in idle and in the last cycle of a word, allowing zero-gap reloads
  always_comb begin
    load_ready = 1'b0;
    case (state_q)
      S_IDLE:   load_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: load_ready = 1'b1;
`else
      S_SHIFT:  load_ready = (cnt_q == '0);
`endif
      default:  load_ready = 1'b0;
    endcase
  end

  assign accept_c = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_SHIFT: begin
        shift_d = shift_q << 1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    // An accepted load only happens in an exit cycle, so it overrides the exit
    if (accept_c) begin
      state_d = S_SHIFT;
      shift_d = data_in;
      cnt_d   = CNT_LAST;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d   = ^data_in;
`endif
    end

    x_d = IDLE_LEVEL;
    case (state_d)
      S_SHIFT:  x_d = shift_d[WIDTH-1];
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: x_d = par_q;
`endif
      default:  x_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != S_IDLE);
`ifdef BIT_SERIALIZER_PARITY_EN
    done_d = (state_d == S_PARITY);
`else
    done_d = (state_d == S_SHIFT) && (cnt_d == '0);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign x_out = x_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed, table-driven bench for bit_serializer (WIDTH=8, IDLE_LEVEL=1).
// Follows BIT_SERIALIZER_PARITY_EN to expect the extra parity cycle.
module tb_bit_serializer;

  localparam int unsigned WIDTH = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             x_out;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             x;
    logic             busy;
    logic             done;
    logic             ready;
  } vec_t;

  vec_t vq[$];

  bit_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .x_out      (x_out),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ex, input logic eb,
                            input logic ed, input logic er);
    check({tag, ".x_out"}, x_out, ex);
    check({tag, ".busy"}, busy, eb);
    check({tag, ".done"}, done, ed);
    check({tag, ".load_ready"}, load_ready, er);
  endtask

  // One row per cycle of a word; ign_at >= 0 pulses a load of 8'hFF on that row
  task automatic add_word(input logic [WIDTH-1:0] d, input int ign_at);
    int len;
    len = WIDTH + PAR;
    for (int k = 0; k < len; k++) begin
      vec_t v;
      v.valid = (k == 0);
      v.data  = (k == 0) ? d : '0;
      if (k == ign_at) begin
        v.valid = 1'b1;
        v.data  = 8'hFF;
      end
      v.x     = (k < WIDTH) ? d[WIDTH-1-k] : ^d;
      v.busy  = 1'b1;
      v.done  = (k == len - 1);
      v.ready = (k == len - 1);
      vq.push_back(v);
    end
  endtask

  task automatic add_idle();
    vec_t v;
    v.valid = 1'b0;
    v.data  = '0;
    v.x     = 1'b1;
    v.busy  = 1'b0;
    v.done  = 1'b0;
    v.ready = 1'b1;
    vq.push_back(v);
  endtask

  // Drive a row, let one rising edge pass, check on the falling edge
  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      load_valid = vq[i].valid;
      data_in    = vq[i].data;
      @(posedge clock);
      @(negedge clock);
      check_outs($sformatf("%s.row%0d", tag, i), vq[i].x, vq[i].busy, vq[i].done, vq[i].ready);
    end
    vq.delete();
    load_valid = 1'b0;
    data_in    = '0;
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;

    // Reset idle
    #2 reset = 1'b1;
    #1 check_outs("rst_t3", 1'b1, 1'b0, 1'b0, 1'b1);
    #10 check_outs("rst_t13", 1'b1, 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_outs($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Single word, back-to-back pair, ignored load, parity word
    add_word(8'b1011_0010, -1);
    add_idle();
    add_word(8'hA5, -1);
    add_word(8'h0F, -1);
    add_idle();
    add_word(8'h00, 3);
    add_idle();
    add_idle();
    add_word(8'b0000_0111, -1);
    add_idle();
    run_table("main");

    // Mid-word reset at bit 4 of 8'hC3
    load_valid = 1'b1;
    data_in    = 8'hC3;
    @(posedge clock);
    @(negedge clock);
    load_valid = 1'b0;
    data_in    = '0;
    check_outs("c3_bit0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("c3_bit%0d.done", k), done, 1'b0);
    end
    check("c3_bit4.x_out", x_out, 1'b0);
    check("c3_bit4.busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1 check_outs("mid_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    check_outs("mid_rst_held", 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check_outs("post_rst", 1'b1, 1'b0, 1'b0, 1'b1);

    add_word(8'h81, -1);
    add_idle();
    run_table("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end that drives the serial input of the Mealy zero detector. Its x_out connects directly to the detector's x_in.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out MSB-first, one bit per clock.
- Holds a programmable idle level between words, so the downstream detector sees a defined, clean bit stream.

Parameters:
- WIDTH, 8, number of data bits per word (minimum 2).
- IDLE_LEVEL, 1'b1, value driven on x_out when no word is being shifted.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  serializer can accept a word this cycle.
- x_out  output  1  serial bit stream to the zero detector's x_in.
- busy  output  1  a word is currently being shifted out.
- done  output  1  one-cycle pulse marking the final bit of a word.

Behaviour:
- Reset (async, active-high) forces the following immediately, independent of clock:
  - state = IDLE, shift register = 0, bit counter = 0.
  - x_out = IDLE_LEVEL, busy = 0, done = 0, load_ready = 1.
- Reset mid-word abandons the word; no done pulse is generated. After reset deasserts, the first accepted load starts a fresh word.
- Handshake:
  - A load is accepted at a rising edge when load_valid && load_ready.
  - data_in is captured at that edge.
  - load_ready is combinational: high in IDLE, and high in the final-bit cycle of SHIFT; low otherwise.
  - load_valid while load_ready is low is ignored; data_in is not sampled.
  - Upstream must hold load_valid and data_in stable until accepted.
- States:
  - IDLE:
    - x_out = IDLE_LEVEL, busy = 0.
    - Accepted load -> SHIFT with bit counter = WIDTH-1.
  - SHIFT:
    - x_out = shift register MSB (registered output).
    - busy = 1.
    - Each clock: shift left by 1 and decrement the counter.
    - Counter == 0 is the final-bit cycle: done = 1.
    - Exit from final-bit cycle with accepted load: reload, stay in SHIFT, counter = WIDTH-1 (zero-gap back-to-back words).
    - Exit from final-bit cycle without a load: -> IDLE.
- Latency: the MSB of a word appears on x_out in the cycle after the accepting edge. The word occupies exactly WIDTH consecutive cycles.
- Widths:
  - Bit counter is clog2(WIDTH) bits.
  - Counter wraps are not permitted; the counter is reloaded, never underflows.
- done is high only in the final data-bit cycle. It is never high in IDLE.
- Reset has priority over all simultaneous events.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - An extra PARITY state follows the last data bit.
  - x_out = even parity (XOR of all WIDTH captured bits) for exactly one cycle.
  - done and load_ready move from the final data-bit cycle to the PARITY cycle.
  - A word occupies WIDTH+1 cycles.
  - Back-to-back loads are accepted in the PARITY cycle.
- Undefined: no PARITY state; behaviour exactly as above.

Test Plan:
- Reset idle: assert reset for 12 ns at t=2, no loads -> x_out=1, busy=0, done=0, load_ready=1 throughout.
- Single word: load 8'b1011_0010 with one-cycle load_valid ->
  - x_out shows 1,0,1,1,0,0,1,0 on the 8 following cycles.
  - done high only on the 8th.
  - x_out returns to 1 afterwards.
- Back-to-back: hold load_valid with 8'hA5, then 8'h0F presented in the final-bit cycle -> 16 contiguous bits 10100101_00001111, no idle gap, two done pulses 8 cycles apart.
- Ignored load: pulse load_valid with 8'hFF at bit 3 of an 8'h00 word -> stream stays all zeros and 8'hFF is not shifted. The downstream detector sees zeros continuously.
- Mid-word reset: assert reset at bit 4 of 8'hC3 -> x_out=1 and busy=0 immediately (before the next edge), no done pulse. A subsequent load of 8'h81 shifts out cleanly.
- Parity build (BIT_SERIALIZER_PARITY_EN defined): load 8'b0000_0111 -> 8 data bits followed by parity bit 1. done is on the 9th cycle.
